// File: rtl/udp_csum_pkg.sv
// ----------------------------------------------------------------------------
// udp_csum_pkg
// Shared definitions for the UDP checksum drain block:
//   - CSUM_DATA_W : FIFO word width (the datapath is byte-laned for 32 bits)
//   - csum_state_e: FSM state encoding
//   - byte_mask() : keep-mask for the final, possibly partial, FIFO word
// ----------------------------------------------------------------------------
package udp_csum_pkg;

  localparam int CSUM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FOLD  = 2'd2,
    ST_OUT   = 2'd3
  } csum_state_e;

  // Bytes are packed big-endian, first byte in [31:24]. len_mod is pkt_len%4;
  // 0 means the last word is full.
  function automatic logic [CSUM_DATA_W-1:0] byte_mask(input logic [1:0] len_mod);
    logic [CSUM_DATA_W-1:0] mask;
    unique case (len_mod)
      2'd1:    mask = 32'hFF00_0000;
      2'd2:    mask = 32'hFFFF_0000;
      2'd3:    mask = 32'hFFFF_FF00;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/udp_checksum_drain_if.sv
// ----------------------------------------------------------------------------
// udp_checksum_drain_if
// Bundles the three handshakes of the checksum drain block:
//   packet descriptor : pkt_len, seed_sum, pkt_vld -> / <- pkt_rdy
//   FIFO read port    : fifo_rd_data, fifo_rd_vld -> / <- fifo_rd_en (FWFT)
//   result            : <- csum, csum_vld / csum_rdy ->
//   status            : <- busy
// master = environment driving packets and FIFO data, slave = the block.
// ----------------------------------------------------------------------------
interface udp_checksum_drain_if #(
  parameter int LEN_W  = 16,
  parameter int DATA_W = udp_csum_pkg::CSUM_DATA_W
);

  logic [LEN_W-1:0]  pkt_len;
  logic [15:0]       seed_sum;
  logic              pkt_vld;
  logic              pkt_rdy;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic              fifo_rd_en;
  logic [15:0]       csum;
  logic              csum_vld;
  logic              csum_rdy;
  logic              busy;

  modport master (
    output pkt_len, seed_sum, pkt_vld, fifo_rd_data, fifo_rd_vld, csum_rdy,
    input  pkt_rdy, fifo_rd_en, csum, csum_vld, busy
  );

  modport slave (
    input  pkt_len, seed_sum, pkt_vld, fifo_rd_data, fifo_rd_vld, csum_rdy,
    output pkt_rdy, fifo_rd_en, csum, csum_vld, busy
  );

endinterface

// File: rtl/udp_csum_add16.sv
// ----------------------------------------------------------------------------
// udp_csum_add16
// 16-bit adder with carry-in and a 17-bit result. The caller feeds the
// previous carry back into cin, which realises the end-around carry of the
// one's-complement sum one step later.
// Ports: a, b (16b operands), cin (pending carry), sum (17b result).
// ----------------------------------------------------------------------------
module udp_csum_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/udp_checksum_drain.sv
// ----------------------------------------------------------------------------
// udp_checksum_drain
// Drains ceil(pkt_len/4) words from a FWFT prefetch FIFO, accumulates the
// one's-complement sum of the payload plus a pseudo-header seed, and offers
// the complemented 16-bit UDP checksum on a valid/ready result port.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset; abandons any packet in flight
//   bus    : udp_checksum_drain_if.slave (descriptor, FIFO pop, result, busy)
//
// Build option:
//   UDP_CSUM_ZERO_MAP_EN : when defined, a computed checksum of 0x0000 is sent
//                          as 0xFFFF (RFC 768 "no checksum" avoidance).
//
// Accumulator invariant: acc <= 0x1FFFE at all times (a 16-bit value plus a
// folded word plus a carry bit never reaches 0x1FFFF), so the single fold in
// FOLD always yields an exact 16-bit result.
// ----------------------------------------------------------------------------
module udp_checksum_drain
  import udp_csum_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int DATA_W = CSUM_DATA_W   // only 32 is supported
) (
  input logic                 clk,
  input logic                 rst_n,
  udp_checksum_drain_if.slave bus
);

  localparam int WL_W = LEN_W - 1;     // holds ceil((2^LEN_W-1)/4)

  csum_state_e       state_q,      state_d;
  logic [16:0]       acc_q,        acc_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic [1:0]        len_mod_q,    len_mod_d;
  logic [15:0]       csum_q,       csum_d;
  logic              csum_vld_q,   csum_vld_d;
  logic              pkt_rdy_q,    pkt_rdy_d;
  logic              fifo_rd_en_q, fifo_rd_en_d;
  logic              busy_q,       busy_d;

  logic [WL_W-1:0]   words_total;
  logic              last_word;
  logic [DATA_W-1:0] word_mask;
  logic [DATA_W-1:0] word_masked;
  logic [16:0]       hi_lo;
  logic [15:0]       word_fold;
  logic [15:0]       add_b;
  logic [16:0]       add_sum;
  logic [15:0]       csum_raw;
  logic [15:0]       csum_out;

  // ceil(pkt_len/4) without a wide adder: whole words plus one if a tail exists.
  assign words_total = {1'b0, bus.pkt_len[LEN_W-1:2]} + WL_W'(|bus.pkt_len[1:0]);
  assign last_word   = (words_left_q == WL_W'(1));

  assign word_mask   = last_word ? byte_mask(len_mod_q) : '1;
  assign word_masked = bus.fifo_rd_data & word_mask;

  // Fold the two halfwords of the popped word to 16 bits first; the result
  // never overflows (max 0x1FFFE -> 0xFFFF).
  assign hi_lo     = {1'b0, word_masked[31:16]} + {1'b0, word_masked[15:0]};
  assign word_fold = hi_lo[15:0] + {15'd0, hi_lo[16]};

  // One shared adder: in DRAIN it adds the word, in FOLD it only absorbs the
  // pending carry (b = 0).
  assign add_b = (state_q == ST_DRAIN) ? word_fold : 16'd0;

  udp_csum_add16 u_add16 (
    .a   (acc_q[15:0]),
    .b   (add_b),
    .cin (acc_q[16]),
    .sum (add_sum)
  );

  assign csum_raw = ~add_sum[15:0];

  always_comb begin
`ifdef UDP_CSUM_ZERO_MAP_EN
    csum_out = (csum_raw == 16'h0000) ? 16'hFFFF : csum_raw;
`else
    csum_out = csum_raw;
`endif
  end

  always_comb begin
    // NOTE: every _d defaults to its _q so no branch can leave a signal
    // unassigned and infer a latch.
    state_d      = state_q;
    acc_d        = acc_q;
    words_left_d = words_left_q;
    len_mod_d    = len_mod_q;
    csum_d       = csum_q;
    csum_vld_d   = csum_vld_q;
    pkt_rdy_d    = pkt_rdy_q;
    fifo_rd_en_d = fifo_rd_en_q;
    busy_d       = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.pkt_vld) begin
          acc_d        = {1'b0, bus.seed_sum};
          words_left_d = words_total;
          len_mod_d    = bus.pkt_len[1:0];
          pkt_rdy_d    = 1'b0;
          busy_d       = 1'b1;
          if (words_total == '0) begin
            state_d = ST_FOLD;
          end else begin
            state_d      = ST_DRAIN;
            fifo_rd_en_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // fifo_rd_en is high throughout DRAIN, so fifo_rd_vld alone marks a pop.
        if (bus.fifo_rd_vld) begin
          acc_d        = add_sum;
          words_left_d = words_left_q - WL_W'(1);
          if (last_word) begin
            state_d      = ST_FOLD;
            fifo_rd_en_d = 1'b0;
          end
        end
      end

      ST_FOLD: begin
        acc_d      = add_sum;
        csum_d     = csum_out;
        csum_vld_d = 1'b1;
        state_d    = ST_OUT;
      end

      ST_OUT: begin
        // pkt_rdy rises only on the way back to IDLE, so no descriptor can be
        // taken in the cycle the result is consumed.
        if (bus.csum_rdy) begin
          csum_vld_d = 1'b0;
          pkt_rdy_d  = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      words_left_q <= '0;
      len_mod_q    <= '0;
      csum_q       <= '0;
      csum_vld_q   <= 1'b0;
      pkt_rdy_q    <= 1'b1;
      fifo_rd_en_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      words_left_q <= words_left_d;
      len_mod_q    <= len_mod_d;
      csum_q       <= csum_d;
      csum_vld_q   <= csum_vld_d;
      pkt_rdy_q    <= pkt_rdy_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.pkt_rdy    = pkt_rdy_q;
  assign bus.fifo_rd_en = fifo_rd_en_q;
  assign bus.csum       = csum_q;
  assign bus.csum_vld   = csum_vld_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_udp_checksum_drain.sv
// ----------------------------------------------------------------------------
// tb_udp_checksum_drain
// Self-checking bench for udp_checksum_drain. A FWFT FIFO model feeds words on
// the falling edge; pops are counted on the rising edge. Expected checksums
// come from a byte-level RFC 768 reference sum computed from the packet bytes.
// ----------------------------------------------------------------------------
module tb_udp_checksum_drain;

  localparam int LEN_W = 16;

`ifdef UDP_CSUM_ZERO_MAP_EN
  localparam logic [15:0] EXP_ALL_ONES = 16'hFFFF;
`else
  localparam logic [15:0] EXP_ALL_ONES = 16'h0000;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  udp_checksum_drain_if #(.LEN_W(LEN_W)) bus ();

  udp_checksum_drain #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fifo_q[$];      // FIFO contents, indexed by absolute pop count
  logic [31:0] pkt_words[$];   // payload words of the packet under test
  int rd_idx        = 0;
  int pops          = 0;
  int pcyc          = 0;
  int last_pop_pcyc = 0;
  int vld_mode      = 0;       // 0: always valid, 1: toggling, 2: random
  bit tog           = 1'b0;

  always @(posedge clk) begin
    pcyc++;
    if (bus.fifo_rd_en === 1'b1 && bus.fifo_rd_vld === 1'b1) begin
      pops++;
      last_pop_pcyc = pcyc;
      rd_idx++;
    end
  end

  always @(negedge clk) begin
    bit want;
    tog = ~tog;
    case (vld_mode)
      0:       want = 1'b1;
      1:       want = tog;
      default: want = 1'($urandom_range(0, 1));
    endcase
    if (rd_idx < fifo_q.size()) begin
      bus.fifo_rd_vld  = want;
      bus.fifo_rd_data = fifo_q[rd_idx];
    end else begin
      bus.fifo_rd_vld  = 1'b0;
      bus.fifo_rd_data = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] byte_at(input int i);
    logic [31:0] w;
    w = pkt_words[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  function automatic logic [15:0] model_csum(input int len, input logic [15:0] seed);
    int unsigned s;
    logic [7:0]  b0, b1;
    logic [15:0] r;
    s = 32'(seed);
    for (int i = 0; i < len; i += 2) begin
      b0 = byte_at(i);
      b1 = (i + 1 < len) ? byte_at(i + 1) : 8'h00;
      s  = s + 32'({b0, b1});
    end
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    r = ~s[15:0];
`ifdef UDP_CSUM_ZERO_MAP_EN
    if (r == 16'h0000) r = 16'hFFFF;
`endif
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_fifo();
    while (fifo_q.size() > rd_idx) void'(fifo_q.pop_back());
    foreach (pkt_words[i]) fifo_q.push_back(pkt_words[i]);
    // Extra words expose any pop beyond the packet length.
    fifo_q.push_back($urandom());
    fifo_q.push_back($urandom());
  endtask

  task automatic fill_words(input int len);
    pkt_words.delete();
    for (int i = 0; i < (len + 3) / 4; i++) pkt_words.push_back($urandom());
  endtask

  // Sends one descriptor (payload in pkt_words), waits for the result, holds
  // csum_rdy low for rdy_delay cycles, then accepts it. got_lat is the number
  // of rising edges from the last pop to the edge that raises csum_vld.
  task automatic run_pkt(input int len, input logic [15:0] seed, input int rdy_delay,
                         output logic [15:0] got, output int got_pops, output int got_lat,
                         output bit held_ok, output bit timed_out);
    int p0;
    bit seen;
    load_fifo();
    p0 = pops; timed_out = 1'b0; held_ok = 1'b1; got = '0; got_lat = -1; got_pops = 0;
    bus.pkt_len  = len[LEN_W-1:0];
    bus.seed_sum = seed;
    bus.pkt_vld  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.pkt_rdy === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      bus.pkt_vld = 1'b0;
      timed_out   = 1'b1;
      return;
    end
    @(negedge clk);
    bus.pkt_vld = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (bus.csum_vld === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      timed_out = 1'b1;
      got_pops  = pops - p0;
      return;
    end
    got     = bus.csum;
    got_lat = pcyc - last_pop_pcyc;
    for (int i = 0; i < rdy_delay; i++) begin
      @(negedge clk);
      if (bus.csum !== got || bus.csum_vld !== 1'b1 || bus.pkt_rdy !== 1'b0 || bus.busy !== 1'b1)
        held_ok = 1'b0;
    end
    bus.csum_rdy = 1'b1;
    @(negedge clk);
    bus.csum_rdy = 1'b0;
    if (bus.csum_vld !== 1'b0 || bus.pkt_rdy !== 1'b1) held_ok = 1'b0;
    got_pops = pops - p0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.pkt_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_pkt_rdy: got %b want 1", bus.pkt_rdy); end
    n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rd_en: got %b want 0", bus.fifo_rd_en); end
    n_checks++; if (bus.csum_vld !== 1'b0) begin n_fail++; $display("FAIL reset_csum_vld: got %b want 0", bus.csum_vld); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.csum !== 16'h0000) begin n_fail++; $display("FAIL reset_csum: got %h want 0000", bus.csum); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    int          lens [4] = '{4, 3, 4, 0};
    logic [15:0] seeds[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h1234};
    logic [31:0] words[4] = '{32'h0001_0002, 32'h1234_5678, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    logic [15:0] exps [4];
    logic [15:0] got;
    int got_pops, got_lat;
    bit held_ok, to;
    exps = '{16'hFFFC, 16'h97CB, EXP_ALL_ONES, 16'hEDCB};
    vld_mode = 0;
    for (int v = 0; v < 4; v++) begin
      pkt_words.delete();
      if (lens[v] > 0) pkt_words.push_back(words[v]);
      run_pkt(lens[v], seeds[v], 1, got, got_pops, got_lat, held_ok, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL vec%0d_timeout: handshake did not complete", v); end
      n_checks++; if (got !== exps[v]) begin n_fail++; $display("FAIL vec%0d_csum: got %h want %h", v, got, exps[v]); end
      n_checks++; if (got_pops !== (lens[v] + 3) / 4) begin n_fail++; $display("FAIL vec%0d_pops: got %0d want %0d", v, got_pops, (lens[v] + 3) / 4); end
      if (lens[v] > 0) begin
        // Pop cycle ends on edge n; csum_vld rises on edge n+1, i.e. it is
        // high in the second cycle after the pop cycle.
        n_checks++; if (got_lat !== 1) begin n_fail++; $display("FAIL vec%0d_latency: got %0d edges want 1", v, got_lat); end
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] got, exp;
    int got_pops, got_lat;
    bit held_ok, to;
    vld_mode = 1;
    fill_words(8);
    exp = model_csum(8, 16'h0000);
    run_pkt(8, 16'h0000, 5, got, got_pops, got_lat, held_ok, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: handshake did not complete"); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL stall_csum: got %h want %h", got, exp); end
    n_checks++; if (got_pops !== 2) begin n_fail++; $display("FAIL stall_pops: got %0d want 2", got_pops); end
    n_checks++; if (held_ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold: outputs not stable / pkt_rdy not low while csum_rdy low, got %b want 1", held_ok); end
    n_checks++; if (got_lat !== 1) begin n_fail++; $display("FAIL stall_latency: got %0d edges want 1", got_lat); end
    vld_mode = 0;
  endtask

  task automatic test_reset_mid();
    int p0;
    bit seen;
    logic [15:0] got, exp;
    int got_pops, got_lat;
    bit held_ok, to;
    vld_mode = 0;
    fill_words(12);
    load_fifo();
    p0 = pops;
    bus.pkt_len  = 16'd12;
    bus.seed_sum = 16'h5A5A;
    bus.pkt_vld  = 1'b1;
    @(negedge clk);
    bus.pkt_vld = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (pops - p0 >= 1) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_first_pop: no pop within bound, got %0d want 1", pops - p0); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b want 0", bus.fifo_rd_en); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.pkt_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pkt_rdy: got %b want 1", bus.pkt_rdy); end
    n_checks++; if (bus.csum !== 16'h0000) begin n_fail++; $display("FAIL rstmid_csum: got %h want 0000", bus.csum); end
    repeat (3) @(negedge clk);
    n_checks++; if (pops - p0 !== 1) begin n_fail++; $display("FAIL rstmid_pops: got %0d want 1", pops - p0); end
    rst_n = 1'b1;
    @(negedge clk);
    fill_words(10);
    exp = model_csum(10, 16'hBEEF);
    run_pkt(10, 16'hBEEF, 0, got, got_pops, got_lat, held_ok, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_next_timeout: handshake did not complete"); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rstmid_next_csum: got %h want %h", got, exp); end
    n_checks++; if (got_pops !== 3) begin n_fail++; $display("FAIL rstmid_next_pops: got %0d want 3", got_pops); end
  endtask

  task automatic test_random();
    int len, dly, exp_pops;
    logic [15:0] seed, got, exp;
    int got_pops, got_lat;
    bit held_ok, to;
    for (int n = 0; n < 24; n++) begin
      len      = $urandom_range(0, 40);
      seed     = 16'($urandom());
      dly      = $urandom_range(0, 3);
      vld_mode = $urandom_range(0, 2);
      exp_pops = (len + 3) / 4;
      fill_words(len);
      exp = model_csum(len, seed);
      run_pkt(len, seed, dly, got, got_pops, got_lat, held_ok, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: handshake did not complete", n); end
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rand%0d_csum: len %0d seed %h got %h want %h", n, len, seed, got, exp); end
      n_checks++; if (got_pops !== exp_pops) begin n_fail++; $display("FAIL rand%0d_pops: got %0d want %0d", n, got_pops, exp_pops); end
      n_checks++; if (held_ok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_hold: got %b want 1", n, held_ok); end
      if (len > 0) begin
        n_checks++; if (got_lat !== 1) begin n_fail++; $display("FAIL rand%0d_latency: got %0d edges want 1", n, got_lat); end
      end
    end
    vld_mode = 0;
  endtask

  initial begin
    bus.pkt_len  = '0;
    bus.seed_sum = '0;
    bus.pkt_vld  = 1'b0;
    bus.csum_rdy = 1'b0;
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
